// File: rtl/multi_clock_divider_if.sv
// Control and status bundle for multi_clock_divider: run enables, sync, divisor
// write port and the per-channel divided outputs.
interface multi_clock_divider_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CH_W     = 2
);
  logic [CHANNELS-1:0] enable;
  logic                syncIn;
  logic                loadEn;
  logic [CH_W-1:0]     loadChannel;
  logic [WIDTH-1:0]    loadDivisor;
  logic [CHANNELS-1:0] clockOut;
  logic [CHANNELS-1:0] tick;
  logic [CHANNELS-1:0] pending;
  logic                loadErr;

  // Controller side: drives enables, sync and divisor writes, observes outputs.
  modport master (
    output enable, syncIn, loadEn, loadChannel, loadDivisor,
    input  clockOut, tick, pending, loadErr
  );

  // Divider side.
  modport slave (
    input  enable, syncIn, loadEn, loadChannel, loadDivisor,
    output clockOut, tick, pending, loadErr
  );
endinterface

// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock divider. Each channel counts 0..D-1 and emits a
// ~50% square wave plus a one-cycle period-start tick. New divisors are held in a
// shadow register and only take effect at a period boundary (or at sync), so a
// running period is never truncated.
module multi_clock_divider #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned CH_W        = 2,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input logic                 clockIn,
  input logic                 resetN,
  multi_clock_divider_if.slave bus
);

  logic [WIDTH-1:0]    d_q [CHANNELS];
  logic [WIDTH-1:0]    d_d [CHANNELS];
  logic [WIDTH-1:0]    s_q [CHANNELS];
  logic [WIDTH-1:0]    s_d [CHANNELS];
  logic [WIDTH-1:0]    c_q [CHANNELS];
  logic [WIDTH-1:0]    c_d [CHANNELS];
  logic [CHANNELS-1:0] p_q, p_d;
  logic [CHANNELS-1:0] tick_q, tick_d;
  logic [CHANNELS-1:0] clock_out_q, clock_out_d;
  logic [CHANNELS-1:0] load_hit;
  logic [CHANNELS-1:0] at_end;
  logic                load_legal;
  logic                err_q, err_d;

  // Load validation and per-channel next-state: sync beats counting, loads always land.
  always_comb begin
    load_legal = bus.loadEn && (bus.loadDivisor >= WIDTH'(2)) &&
                 (int'(bus.loadChannel) < int'(CHANNELS));
    err_d      = err_q | (bus.loadEn & ~load_legal);
    load_hit   = '0;
    at_end     = '0;
    p_d        = p_q;
    tick_d     = '0;
    clock_out_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      d_d[i]      = d_q[i];
      s_d[i]      = s_q[i];
      c_d[i]      = c_q[i];
      load_hit[i] = load_legal && (int'(bus.loadChannel) == i);
      at_end[i]   = (c_q[i] == d_q[i] - WIDTH'(1));
      if (bus.syncIn) begin
        c_d[i] = '0;
        // A write coinciding with sync bypasses the shadow entirely.
        if (load_hit[i]) begin
          d_d[i] = bus.loadDivisor;
          s_d[i] = bus.loadDivisor;
          p_d[i] = 1'b0;
        end else if (p_q[i]) begin
          d_d[i] = s_q[i];
          p_d[i] = 1'b0;
        end
      end else begin
        if (bus.enable[i]) begin
          if (at_end[i]) begin
            c_d[i]    = '0;
            tick_d[i] = 1'b1;
            // Boundary consumes the shadow as it stood before this edge.
            if (p_q[i]) begin
              d_d[i] = s_q[i];
              p_d[i] = 1'b0;
            end
          end else begin
            c_d[i] = c_q[i] + WIDTH'(1);
          end
        end
        // A write on the boundary edge re-arms pending for the following boundary.
        if (load_hit[i]) begin
          s_d[i] = bus.loadDivisor;
          p_d[i] = 1'b1;
        end
      end
      // Registered from next-state values so the output flop tracks C >= D/2 exactly.
      clock_out_d[i] = (c_d[i] >= (d_d[i] >> 1));
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clockIn) begin
    if (!resetN) begin
      for (int i = 0; i < CHANNELS; i++) begin
        d_q[i] <= WIDTH'(DEFAULT_DIV);
        s_q[i] <= WIDTH'(DEFAULT_DIV);
        c_q[i] <= '0;
      end
      p_q         <= '0;
      tick_q      <= '0;
      clock_out_q <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        d_q[i] <= d_d[i];
        s_q[i] <= s_d[i];
        c_q[i] <= c_d[i];
      end
      p_q         <= p_d;
      tick_q      <= tick_d;
      clock_out_q <= clock_out_d;
      err_q       <= err_d;
    end
  end

  assign bus.clockOut = clock_out_q;
  assign bus.tick     = tick_q;
  assign bus.pending  = p_q;
  assign bus.loadErr  = err_q;

endmodule
